// File: rtl/r5p_tcb_arbiter.sv
// Two-requester TCB arbiter: shares one DLY=1 system bus between two managers,
// holds the grant across a stalled request and routes each response to its owner.
module r5p_tcb_arbiter #(
    parameter int unsigned ABW    = 32,
    parameter int unsigned DBW    = 32,
    parameter bit          ARB_RR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    // requester side
    input  logic [1:0]          sub_vld,
    input  logic [1:0]          sub_wen,
    input  logic [1:0][ABW-1:0] sub_adr,
    input  logic [1:0][2:0]     sub_fn3,
    input  logic [1:0][DBW-1:0] sub_wdt,
    output logic [1:0][DBW-1:0] sub_rdt,
    output logic [1:0]          sub_err,
    output logic [1:0]          sub_rdy,
    // shared bus side
    output logic                man_vld,
    output logic                man_wen,
    output logic [ABW-1:0]      man_adr,
    output logic [2:0]          man_fn3,
    output logic [DBW-1:0]      man_wdt,
    input  logic [DBW-1:0]      man_rdt,
    input  logic                man_err,
    input  logic                man_rdy
);

    logic       lck;      // grant held for a stalled request
    logic       lck_id;   // owner of the held grant
    logic       lst;      // last requester that completed a transfer
    logic       rsp_vld;  // a response is due this cycle
    logic       rsp_id;   // owner of that response
    logic [1:0] gnt;
    logic       gid;
    logic       man_trn;

    // Grant selection; forced idle while reset is asserted.
    always_comb begin
        gnt = 2'b00;
        if (!rst_n) begin
            gnt = 2'b00;
        end else if (lck) begin
            gnt = lck_id ? 2'b10 : 2'b01;
        end else if (&sub_vld) begin
            // round-robin favours the requester that did not go last
            gnt = (ARB_RR && !lst) ? 2'b10 : 2'b01;
        end else begin
            gnt = sub_vld;
        end
    end

    assign gid     = gnt[1];
    assign man_trn = man_vld & man_rdy;
    assign sub_rdy = gnt & {2{man_rdy}};

    // Request mux: granted requester drives the shared bus, zeros when idle.
    always_comb begin
        man_vld = |(sub_vld & gnt);
        man_wen = 1'b0;
        man_adr = '0;
        man_fn3 = '0;
        man_wdt = '0;
        unique case (gnt)
            2'b01: begin
                man_wen = sub_wen[0];
                man_adr = sub_adr[0];
                man_fn3 = sub_fn3[0];
                man_wdt = sub_wdt[0];
            end
            2'b10: begin
                man_wen = sub_wen[1];
                man_adr = sub_adr[1];
                man_fn3 = sub_fn3[1];
                man_wdt = sub_wdt[1];
            end
            default: ;
        endcase
    end

    // Lock, round-robin history and response ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lck     <= 1'b0;
            lck_id  <= 1'b0;
            lst     <= 1'b1;
            rsp_vld <= 1'b0;
            rsp_id  <= 1'b0;
        end else begin
            // a stalled request keeps the grant; a dropped owner releases it
            lck <= man_vld & ~man_rdy;
            if (man_vld & ~man_rdy) begin
                lck_id <= gid;
            end
            rsp_vld <= man_trn;
            if (man_trn) begin
                lst    <= gid;
                rsp_id <= gid;
            end
        end
    end

    // Response demux: only the owner of last cycle's transfer sees data.
    always_comb begin
        sub_rdt = '0;
        sub_err = '0;
        if (rsp_vld) begin
            sub_rdt[rsp_id] = man_rdt;
            sub_err[rsp_id] = man_err;
        end
    end

endmodule
